// File: rtl/hevc_pkg.sv
// Shared HEVC dataflow definitions: payload width, tag sizing and the tagged word type.
package hevc_pkg;

  localparam int DATA_WIDTH = 8;

  // Tag bits needed to name one of 'flux' channels; never narrower than one bit.
  function automatic int tag_width(input int flux);
    return (flux <= 2) ? 1 : $clog2(flux);
  endfunction

  localparam int DEFAULT_FLUX = 2;
  localparam int WORD_WIDTH   = DATA_WIDTH + tag_width(DEFAULT_FLUX);

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/multi_flux_fifo_if.sv
// Bus bundle between producers, the multi-flux FIFO bank and the downstream delayer.
interface fifo_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 9
);
  logic [FLUX-1:0]  write;
  logic [WIDTH-1:0] din;
  logic [FLUX-1:0]  full;
  logic [FLUX-1:0]  read;
  logic [FLUX-1:0]  empty;
  logic [WIDTH-1:0] dout;

  // FIFO bank side: slave of both the write and the read groups.
  modport fifo (
    input  write, din, read,
    output full, empty, dout
  );

  // Producer side of the write group.
  modport writer (
    output write, din,
    input  full
  );

  // Consumer (delayer) side of the read group.
  modport reader (
    output read,
    input  empty, dout
  );
endinterface

// File: rtl/multi_flux_fifo_channel.sv
// Single circular FIFO with first-word-fall-through head output; one per flux.
module fifo_channel #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/multi_flux_fifo.sv
// Bank of FLUX independent FIFOs with a one-hot read select feeding a shared dout.
// Optional sticky protocol error flags are built when MULTI_FLUX_FIFO_ERR_EN is defined.
module multi_flux_fifo
  import hevc_pkg::tag_width;
#(
  parameter int FLUX       = 2,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = hevc_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = tag_width(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic clk,
  input  logic rst,
  fifo_interface.fifo bus
`ifdef MULTI_FLUX_FIFO_ERR_EN
  ,
  output logic [2:0] err
`endif
);

  logic [WIDTH-1:0]     heads [FLUX];
  logic [FLUX-1:0]      full_v;
  logic [FLUX-1:0]      empty_v;
  logic [FLUX-1:0]      pop;
  logic [TAG_WIDTH-1:0] sel;

  // Highest asserted read bit wins; with no read the head of flux 0 is shown.
  always_comb begin
    sel = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (bus.read[i]) sel = TAG_WIDTH'(i);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < FLUX; i++) begin
      pop[i] = bus.read[i] && (sel == TAG_WIDTH'(i));
    end
  end

  genvar g;
  generate
    for (g = 0; g < FLUX; g++) begin : g_chan
      fifo_channel #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.write[g]),
        .pop   (pop[g]),
        .din   (bus.din),
        .full  (full_v[g]),
        .empty (empty_v[g]),
        .head  (heads[g])
      );
    end
  endgenerate

  assign bus.full  = full_v;
  assign bus.empty = empty_v;
  assign bus.dout  = heads[sel];

`ifdef MULTI_FLUX_FIFO_ERR_EN
  logic [2:0] err_q;
  logic [2:0] err_ev;

  assign err_ev[0] = |(bus.write & full_v);
  assign err_ev[1] = |(bus.read & empty_v);
  assign err_ev[2] = (bus.read & (bus.read - 1'b1)) != '0;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_q | err_ev;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_multi_flux_fifo.sv
// Randomised and directed bench for multi_flux_fifo against a queue-based reference model.
module tb_multi_flux_fifo;
  localparam int FLUX  = 2;
  localparam int DEPTH = 4;
  localparam int WIDTH = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_interface #(.FLUX(FLUX), .WIDTH(WIDTH)) bus ();

`ifdef MULTI_FLUX_FIFO_ERR_EN
  logic [2:0] err;
`endif

  multi_flux_fifo #(.FLUX(FLUX), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MULTI_FLUX_FIFO_ERR_EN
    ,
    .err (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q [FLUX][$];
  logic [2:0]       err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: check outputs against the model, clock, then advance the model.
  task automatic cycle(input logic [1:0] w, input logic [WIDTH-1:0] d,
                       input logic [1:0] r, input logic rs);
    int         sel;
    bit         pop_ok  [FLUX];
    bit         push_ok [FLUX];
    logic [1:0] em, fm;
    logic [2:0] ev;
    bus.write = w;
    bus.din   = d;
    bus.read  = r;
    rst       = rs;
    #1;
    em = {q[1].size() == 0, q[0].size() == 0};
    fm = {q[1].size() == DEPTH, q[0].size() == DEPTH};
    check("empty", 32'(bus.empty), 32'(em));
    check("full", 32'(bus.full), 32'(fm));
    sel = r[1] ? 1 : 0;
    if (q[sel].size() > 0) check("dout", 32'(bus.dout), 32'(q[sel][0]));
`ifdef MULTI_FLUX_FIFO_ERR_EN
    check("err", 32'(err), 32'(err_m));
`endif
    ev = {r == 2'b11, |(r & em), |(w & fm)};
    for (int i = 0; i < FLUX; i++) begin
      pop_ok[i]  = r[i] && (i == sel) && (q[i].size() > 0);
      push_ok[i] = w[i] && (q[i].size() < DEPTH);
    end
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < FLUX; i++) q[i].delete();
      err_m = '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (pop_ok[i])  void'(q[i].pop_front());
        if (push_ok[i]) q[i].push_back(d);
      end
      err_m = err_m | ev;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rr;
    rst       = 1'b1;
    bus.write = '0;
    bus.read  = '0;
    bus.din   = '0;
    err_m     = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (4) cycle(2'b00, '0, 2'b00, 1'b0);
    check("rst_empty", 32'(bus.empty), 32'h3);
    check("rst_full", 32'(bus.full), 32'h0);

    // Fill flux 1, overflow attempt, drain in order
    for (int k = 0; k < 4; k++) cycle(2'b10, WIDTH'(9'h101 + k), 2'b00, 1'b0);
    check("full_after4", 32'(bus.full), 32'h2);
    cycle(2'b10, 9'h1FF, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.read = 2'b10;
      #1;
      check("drain_order", 32'(bus.dout), 32'(9'h101 + k));
      cycle(2'b00, '0, 2'b10, 1'b0);
    end
    check("drained_empty1", 32'(bus.empty[1]), 32'h1);

    // Simultaneous push and pop at count 2
    cycle(2'b10, 9'h131, 2'b00, 1'b0);
    cycle(2'b10, 9'h132, 2'b00, 1'b0);
    cycle(2'b10, 9'h133, 2'b10, 1'b0);
    bus.read = 2'b10;
    #1;
    check("pp_head", 32'(bus.dout), 32'h132);
    for (int k = 0; k < 2; k++) cycle(2'b00, '0, 2'b10, 1'b0);

    // Full flux: pop accepted, push dropped
    for (int k = 0; k < 4; k++) cycle(2'b10, WIDTH'(9'h141 + k), 2'b00, 1'b0);
    cycle(2'b10, 9'h1AA, 2'b10, 1'b0);
    check("full_pp_full", 32'(bus.full), 32'h0);
    for (int k = 0; k < 3; k++) cycle(2'b00, '0, 2'b10, 1'b0);
    check("full_pp_empty", 32'(bus.empty), 32'h3);

    // Interleaved fluxes and pointer wrap
    cycle(2'b01, 9'h011, 2'b00, 1'b0);
    cycle(2'b10, 9'h122, 2'b00, 1'b0);
    cycle(2'b00, '0, 2'b01, 1'b0);
    cycle(2'b00, '0, 2'b10, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cycle(2'b01, WIDTH'($urandom), 2'b00, 1'b0);
      cycle(2'b00, '0, 2'b01, 1'b0);
      cycle(2'b10, WIDTH'($urandom), 2'b00, 1'b0);
      cycle(2'b00, '0, 2'b10, 1'b0);
    end

`ifdef MULTI_FLUX_FIFO_ERR_EN
    // Protocol-error flags
    cycle(2'b00, '0, 2'b00, 1'b1);
    cycle(2'b01, 9'h055, 2'b00, 1'b0);
    cycle(2'b10, 9'h166, 2'b00, 1'b0);
    cycle(2'b00, '0, 2'b11, 1'b0);
    check("err_multi", 32'(err), 32'h4);
    check("err_multi_empty", 32'(bus.empty), 32'h2);
    cycle(2'b00, '0, 2'b00, 1'b1);
    check("err_rst", 32'(err), 32'h0);
    check("err_rst_empty", 32'(bus.empty), 32'h3);
`endif

    // Random traffic with occasional illegal reads and resets
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rr = 2'b00;
        3, 4, 5: rr = 2'b01;
        6, 7, 8: rr = 2'b10;
        default: rr = 2'b11;
      endcase
      cycle(2'($urandom_range(0, 3)), WIDTH'($urandom), rr, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
